wb_arbiter_2m: RTL

- Two-master, one-slave classic Wishbone arbiter.
- Sits directly upstream of the SRAM controller's bus slave port.
- Master 0 is the CPU instruction-fetch port; master 1 is the CPU data port.
- Round-robin grant, grant held for the whole cyc, bus timeout that returns err so a silent slave cannot hang the CPU.

---
 rtl/wb_arbiter_2m.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master classic Wishbone arbiter: round-robin grant held for a whole cyc, plus a
// stall timeout that answers err so a silent slave cannot hang the CPU.
module wb_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      clk_bus,
    input  logic                      rst_bus,
    input  logic [2*ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [2*DATA_WIDTH-1:0]   m_dat_i,
    input  logic [2*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [1:0]                m_we_i,
    input  logic [1:0]                m_cyc_i,
    input  logic [1:0]                m_stb_i,
    output logic [DATA_WIDTH-1:0]     m_dat_o,
    output logic [1:0]                m_ack_o,
    output logic [1:0]                m_err_o,
    output logic [ADDR_WIDTH-1:0]     s_adr_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    input  logic [DATA_WIDTH-1:0]     s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    output logic                      gnt_o
);

    localparam int unsigned SelW = DATA_WIDTH / 8;
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the stalled cycle that would bring the count up to TIMEOUT.
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          r_state, w_state_d;
    logic            r_gnt, w_gnt_d;
    logic            r_last_gnt, w_last_gnt_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;

    logic [1:0] w_req;
    logic       w_busy, w_cyc, w_stall, w_abort, w_winner;

    always_comb begin
        w_req    = m_cyc_i & m_stb_i;
        w_busy   = (r_state == StBusy);
        w_cyc    = w_busy & m_cyc_i[r_gnt];
        w_stall  = w_cyc & m_stb_i[r_gnt] & ~s_ack_i & ~s_err_i;
        w_abort  = (TIMEOUT != 0) && w_stall && (r_cnt == CntLast);
        w_winner = (&w_req) ? ~r_last_gnt : w_req[1];
    end

    // Slave side: nothing leaves the arbiter unless a grant is live.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = w_cyc;
        s_stb_o = w_cyc & m_stb_i[r_gnt] & ~w_abort;
        if (w_busy) begin
            s_adr_o = r_gnt ? m_adr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_adr_i[ADDR_WIDTH-1:0];
            s_dat_o = r_gnt ? m_dat_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_dat_i[DATA_WIDTH-1:0];
            s_sel_o = r_gnt ? m_sel_i[2*SelW-1:SelW] : m_sel_i[SelW-1:0];
            s_we_o  = m_we_i[r_gnt];
        end
    end

    // Responses reach only the owner, and only while it still holds cyc (drops late acks).
    always_comb begin
        m_ack_o = 2'b00;
        m_err_o = 2'b00;
        if (w_cyc) begin
            m_ack_o[r_gnt] = s_ack_i & ~s_err_i;
            m_err_o[r_gnt] = s_err_i | w_abort;
        end
    end

    assign m_dat_o = s_dat_i;
    assign gnt_o   = r_gnt;

    always_comb begin
        w_state_d    = r_state;
        w_gnt_d      = r_gnt;
        w_last_gnt_d = r_last_gnt;
        unique case (r_state)
            StIdle: begin
                if (|w_req) begin
                    w_state_d    = StBusy;
                    w_gnt_d      = w_winner;
                    w_last_gnt_d = w_winner;
                end
            end
            StBusy: begin
                if (!m_cyc_i[r_gnt]) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_cnt_d = '0;
        if ((TIMEOUT != 0) && w_stall && !w_abort) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (!rst_bus) begin
            r_state    <= StIdle;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_gnt      <= w_gnt_d;
            r_last_gnt <= w_last_gnt_d;
            r_cnt      <= w_cnt_d;
        end
    end

endmodule
